// File: rtl/tqvp_timer_capture_pkg.sv
// tqvp_timer_pkg: register map, CTRL/STATUS bit positions and bus write-size helpers for the timer
package tqvp_timer_pkg;
    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_PRESCALE = 6'h04;
    localparam logic [5:0] ADDR_COUNT    = 6'h08;
    localparam logic [5:0] ADDR_RELOAD   = 6'h0C;
    localparam logic [5:0] ADDR_COMPARE  = 6'h10;
    localparam logic [5:0] ADDR_CAPTURE  = 6'h14;
    localparam logic [5:0] ADDR_STATUS   = 6'h18;
    localparam logic [5:0] ADDR_IRQ_EN   = 6'h1C;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_ONESHOT  = 1;
    localparam int CTRL_CAP_EN   = 2;
    localparam int CTRL_CAP_SEL  = 3;
    localparam int CTRL_CAP_FALL = 6;
    localparam int CTRL_PWM_EN   = 7;
    localparam int ST_WRAP = 0;
    localparam int ST_CAP  = 1;
    localparam int ST_OVR  = 2;
    typedef enum logic [1:0] {WR_8 = 2'b00, WR_16 = 2'b01, WR_32 = 2'b10, WR_NONE = 2'b11} wsize_e;
    function automatic logic [31:0] wmerge(logic [31:0] old, logic [31:0] din, logic [1:0] wn);
        return wn == WR_8 ? {old[31:8], din[7:0]} : wn == WR_16 ? {old[31:16], din[15:0]} :
               wn == WR_32 ? din : old;
    endfunction
endpackage

// File: rtl/tqvp_timer_capture_if.sv
// tqvp_timer_capture_if: peripheral bus between the wrapper (master) and the timer (slave)
interface tqvp_timer_capture_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;
    modport master (output address, data_in, data_write_n, data_read_n,
                    input data_out, data_ready, user_interrupt);
    modport slave  (input address, data_in, data_write_n, data_read_n,
                    output data_out, data_ready, user_interrupt);
endinterface

// File: rtl/tqvp_timer_capture_prescaler.sv
// tqvp_timer_prescaler: counts 0..prescale while enabled, tick in the cycle it reaches prescale
module tqvp_timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);
    logic [PRE_W-1:0] pcnt;
    assign tick = en && pcnt == prescale;
    always_ff @(posedge clk)
        if (rst || clr || !en) pcnt <= '0;
        else pcnt <= tick ? '0 : pcnt + PRE_W'(1);
endmodule

// File: rtl/tqvp_timer_capture.sv
// tqvp_timer_capture: prescaled 32-bit auto-reload timer with PWM on uo_out[0] and edge capture of ui_in
module tqvp_timer_capture
    import tqvp_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    tqvp_timer_capture_if.slave bus
);
    logic [7:0]       ctrl;
    logic [PRE_W-1:0] prescale;
    logic [CNT_W-1:0] count, reload, compare, capture;
    logic [2:0]       status, w1c;
    logic [1:0]       irq_en;
    logic prev, now, pwm, irq, tick, hit, wrap_ev, cap_hit;
    logic we, wr_ctrl, wr_pre, wr_cnt, wr_rel, wr_cmp, wr_st, wr_ien;

    assign we      = bus.data_write_n != WR_NONE;
    assign wr_ctrl = we && bus.address == ADDR_CTRL;
    assign wr_pre  = we && bus.address == ADDR_PRESCALE;
    assign wr_cnt  = we && bus.address == ADDR_COUNT;
    assign wr_rel  = we && bus.address == ADDR_RELOAD;
    assign wr_cmp  = we && bus.address == ADDR_COMPARE;
    assign wr_st   = we && bus.address == ADDR_STATUS;
    assign wr_ien  = we && bus.address == ADDR_IRQ_EN;
    assign w1c     = wr_st ? bus.data_in[2:0] : 3'b0;

    // A PRESCALE write restarts the phase so a smaller value can never be skipped over.
    tqvp_timer_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk(clk), .rst(rst), .en(ctrl[CTRL_EN]), .clr(wr_pre), .prescale(prescale), .tick(tick)
    );

    // A COUNT write in a tick cycle also suppresses the reload event it would have caused.
    assign hit     = count == reload;
    assign wrap_ev = tick && hit && !wr_cnt;
    assign now     = ui_in[ctrl[CTRL_CAP_SEL +: 3]];
    assign cap_hit = ctrl[CTRL_CAP_EN] && (ctrl[CTRL_CAP_FALL] ? prev && !now : !prev && now);

    assign uo_out             = {7'b0, pwm};
    assign bus.data_ready     = 1'b1;
    assign bus.user_interrupt = irq;

    always_ff @(posedge clk)
        if (rst) begin
            ctrl     <= '0;
            prescale <= '0;
            count    <= '0;
            reload   <= '0;
            compare  <= '0;
            capture  <= '0;
            status   <= '0;
            irq_en   <= '0;
            prev     <= 1'b0;
            pwm      <= 1'b0;
            irq      <= 1'b0;
        end else begin
            prev     <= now;
            pwm      <= ctrl[CTRL_PWM_EN] && count < compare;
            irq      <= |(status[1:0] & irq_en);
            ctrl     <= wr_ctrl ? 8'(wmerge(32'(ctrl), bus.data_in, bus.data_write_n)) :
                        wrap_ev && ctrl[CTRL_ONESHOT] ? ctrl & 8'hFE : ctrl;
            prescale <= wr_pre ? PRE_W'(wmerge(32'(prescale), bus.data_in, bus.data_write_n)) : prescale;
            count    <= wr_cnt ? CNT_W'(wmerge(32'(count), bus.data_in, bus.data_write_n)) :
                        tick ? (hit ? '0 : count + CNT_W'(1)) : count;
            reload   <= wr_rel ? CNT_W'(wmerge(32'(reload), bus.data_in, bus.data_write_n)) : reload;
            compare  <= wr_cmp ? CNT_W'(wmerge(32'(compare), bus.data_in, bus.data_write_n)) : compare;
            capture  <= cap_hit ? count : capture;
            status   <= (status & ~w1c) | {cap_hit && status[ST_CAP], cap_hit, wrap_ev};
            irq_en   <= wr_ien ? 2'(wmerge(32'(irq_en), bus.data_in, bus.data_write_n)) : irq_en;
        end

    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            ADDR_CTRL:     bus.data_out = 32'(ctrl);
            ADDR_PRESCALE: bus.data_out = 32'(prescale);
            ADDR_COUNT:    bus.data_out = 32'(count);
            ADDR_RELOAD:   bus.data_out = 32'(reload);
            ADDR_COMPARE:  bus.data_out = 32'(compare);
            ADDR_CAPTURE:  bus.data_out = 32'(capture);
            ADDR_STATUS:   bus.data_out = 32'(status);
            ADDR_IRQ_EN:   bus.data_out = 32'(irq_en);
            default:       bus.data_out = '0;
        endcase
    end
endmodule

// File: tb/tb_tqvp_timer_capture.sv
// tb_tqvp_timer_capture: directed plus random checks of the timer against a register-level reference model
module tb_tqvp_timer_capture;
    logic clk = 0, rst = 1;
    logic [7:0] ui_in = 0, uo_out;
    int tests = 0, fails = 0;
    tqvp_timer_capture_if bus();
    tqvp_timer_capture dut (.clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .bus(bus));
    always #10 clk = ~clk;

    logic [31:0] m_ctrl, m_pre, m_pcnt, m_count, m_reload, m_compare, m_cap, m_status, m_irqen;
    logic m_prev, m_pwm, m_irq;

    function automatic logic [31:0] mrg(logic [31:0] old, logic [31:0] din, logic [1:0] wn);
        logic [31:0] msk;
        msk = wn == 2'b00 ? 32'hFF : wn == 2'b01 ? 32'hFFFF : 32'hFFFF_FFFF;
        return (old & ~msk) | (din & msk);
    endfunction

    function automatic logic [31:0] m_read(logic [5:0] a);
        case (a)
            6'h00: return m_ctrl;
            6'h04: return m_pre;
            6'h08: return m_count;
            6'h0C: return m_reload;
            6'h10: return m_compare;
            6'h14: return m_cap;
            6'h18: return m_status;
            6'h1C: return m_irqen;
            default: return 0;
        endcase
    endfunction

    // One clock edge of the timer as the register map describes it, from pre-edge state and inputs.
    task automatic model_step();
        logic we, tick, hit, wrapev, now, edg, caph;
        logic [5:0] a;
        logic [1:0] wn;
        logic [31:0] d;
        logic [2:0] w1c;
        if (rst) begin
            {m_ctrl, m_pre, m_pcnt, m_count, m_reload, m_compare, m_cap, m_status, m_irqen} = '0;
            {m_prev, m_pwm, m_irq} = '0;
            return;
        end
        a = bus.address; wn = bus.data_write_n; d = bus.data_in;
        we = wn != 2'b11;
        tick = m_ctrl[0] && m_pcnt == m_pre;
        hit = m_count == m_reload;
        now = ui_in[m_ctrl[5:3]];
        edg = m_ctrl[6] ? (m_prev && !now) : (!m_prev && now);
        caph = edg && m_ctrl[2];
        wrapev = tick && hit && !(we && a == 6'h08);
        m_pwm = m_ctrl[7] && m_count < m_compare;
        m_irq = |(m_status[1:0] & m_irqen[1:0]);
        m_prev = now;
        m_pcnt = (!m_ctrl[0] || tick || (we && a == 6'h04)) ? 0 : m_pcnt + 1;
        if (caph) m_cap = m_count;
        w1c = (we && a == 6'h18) ? d[2:0] : 3'b0;
        m_status = (m_status & ~32'(w1c)) | 32'({caph && m_status[1], caph, wrapev});
        if (we && a == 6'h08) m_count = mrg(m_count, d, wn);
        else if (tick) m_count = hit ? 0 : m_count + 1;
        if (we && a == 6'h00) m_ctrl = mrg(m_ctrl, d, wn) & 32'hFF;
        else if (wrapev && m_ctrl[1]) m_ctrl[0] = 1'b0;
        if (we && a == 6'h04) m_pre = mrg(m_pre, d, wn) & 32'hFFFF;
        if (we && a == 6'h0C) m_reload = mrg(m_reload, d, wn);
        if (we && a == 6'h10) m_compare = mrg(m_compare, d, wn);
        if (we && a == 6'h1C) m_irqen = mrg(m_irqen, d, wn) & 32'h3;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] wn = 2'b11, input logic [5:0] a = 6'h3F, input logic [31:0] d = 0);
        bus.data_write_n = wn; bus.address = a; bus.data_in = d;
        @(posedge clk);
        model_step();
        #1;
        bus.data_write_n = 2'b11;
        chk("uo_out", 32'(uo_out), 32'({7'b0, m_pwm}));
        chk("irq", 32'(bus.user_interrupt), 32'(m_irq));
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        step(2'b10, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rdc(input logic [5:0] a, input logic [31:0] exp, input string tag);
        bus.address = a; bus.data_write_n = 2'b11;
        #1;
        chk(tag, bus.data_out, exp);
    endtask

    task automatic rdm(input logic [5:0] a);
        bus.address = a; bus.data_write_n = 2'b11;
        #1;
        chk($sformatf("read_%02h", a), bus.data_out, m_read(a));
    endtask

    initial begin
        int hi;
        logic [5:0] amap [10] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h02};
        bus.data_read_n = 2'b11; bus.data_write_n = 2'b11; bus.address = 0; bus.data_in = 0;
        idle(3);
        rst = 0;
        for (int i = 0; i < 8; i++) rdc(6'(i * 4), 0, "reset_reg");
        chk("reset_ready", 32'(bus.data_ready), 1);

        wr(6'h04, 2); wr(6'h0C, 3); wr(6'h00, 1);
        for (int k = 1; k <= 15; k++) begin
            step();
            rdc(6'h08, 32'((k / 3) % 4), "cnt_seq");
        end
        rdc(6'h18, 1, "wrap_set");
        wr(6'h18, 1);
        rdc(6'h18, 0, "wrap_clr");
        wr(6'h00, 0);

        wr(6'h08, 0); wr(6'h0C, 9); wr(6'h10, 4); wr(6'h04, 0); wr(6'h00, 32'h81);
        idle(2);
        hi = 0;
        for (int i = 0; i < 20; i++) begin step(); hi += int'(uo_out[0]); end
        chk("pwm_duty", 32'(hi), 8);
        wr(6'h10, 0); idle(2);
        hi = 0;
        for (int i = 0; i < 12; i++) begin step(); hi += int'(uo_out[0]); end
        chk("pwm_cmp0", 32'(hi), 0);
        wr(6'h10, 20); idle(2);
        hi = 0;
        for (int i = 0; i < 12; i++) begin step(); hi += int'(uo_out[0]); end
        chk("pwm_cmp_big", 32'(hi), 12);
        wr(6'h00, 0);

        wr(6'h08, 0); wr(6'h0C, 5); wr(6'h18, 7); wr(6'h00, 3);
        idle(12);
        rdc(6'h00, 2, "oneshot_ctrl");
        rdc(6'h08, 0, "oneshot_cnt");
        rdc(6'h18, 1, "oneshot_wrap");

        wr(6'h18, 7); wr(6'h0C, 100); wr(6'h08, 0); wr(6'h1C, 2);
        ui_in = 0;
        wr(6'h00, 32'h1D);
        idle(5);
        ui_in = 8'h08; step();
        rdc(6'h14, 5, "cap_value");
        rdc(6'h18, 2, "cap_flag");
        step();
        chk("cap_irq", 32'(bus.user_interrupt), 1);
        ui_in = 0; idle(2);
        ui_in = 8'h08; step();
        rdc(6'h18, 6, "cap_ovr");
        wr(6'h18, 6);
        rdc(6'h18, 0, "cap_clr");
        step();
        chk("cap_irq_clr", 32'(bus.user_interrupt), 0);

        wr(6'h00, 1);
        wr(6'h08, 32'h100);
        rdc(6'h08, 32'h100, "cnt_write_wins");
        wr(6'h00, 0);
        wr(6'h0C, 3); wr(6'h08, 0); wr(6'h18, 7); wr(6'h00, 1);
        idle(3);
        rdc(6'h08, 3, "pre_wrap_cnt");
        wr(6'h18, 1);
        rdc(6'h18, 1, "set_beats_w1c");
        wr(6'h00, 0);
        wr(6'h0C, 32'h12345678);
        step(2'b00, 6'h0C, 32'hFFFF_FFAB);
        rdc(6'h0C, 32'h123456AB, "wr8");
        step(2'b01, 6'h0C, 32'hFFFF_CDEF);
        rdc(6'h0C, 32'h1234CDEF, "wr16");

        wr(6'h18, 7); wr(6'h0C, 5); wr(6'h08, 32'hFFFF_FFFE); wr(6'h00, 1);
        idle(2);
        rdc(6'h08, 0, "mod_wrap_cnt");
        rdc(6'h18, 0, "mod_wrap_nowrap");
        idle(6);
        rdc(6'h18, 1, "reload_after_mod");

        for (int i = 0; i < 400; i++) begin
            logic [5:0] a;
            logic [31:0] d;
            ui_in = 8'($urandom);
            a = amap[$urandom_range(0, 9)];
            d = $urandom;
            case (a)
                6'h04: d = $urandom_range(0, 3);
                6'h08, 6'h10: d = $urandom_range(0, 20);
                6'h0C: d = $urandom_range(0, 15);
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) step(2'($urandom_range(0, 2)), a, d);
            else step();
            rdm(amap[$urandom_range(0, 9)]);
        end

        wr(6'h00, 0); wr(6'h18, 7); wr(6'h04, 0); wr(6'h0C, 2); wr(6'h08, 0); wr(6'h1C, 1);
        wr(6'h00, 1);
        idle(5);
        chk("irq_pending", 32'(bus.user_interrupt), 1);
        rst = 1; step(); rst = 0;
        chk("rst_uo", 32'(uo_out), 0);
        chk("rst_irq", 32'(bus.user_interrupt), 0);
        rdc(6'h08, 0, "rst_count");
        rdc(6'h00, 0, "rst_ctrl");
        rdc(6'h18, 0, "rst_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
